// File: rtl/regfile_opfetch_pkg.sv
// Shared widths and bundle types for the register-file operand fetch unit.
package regfile_pkg;

    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          we;
    } opf_entry_t;

    typedef logic [NREG-1:0] sb_vec_t;

endpackage

// File: rtl/regfile_opfetch_skid_fifo.sv
// Two-entry operand buffer; push and pop may coincide at any fill level.
module opf_skid_fifo
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  opf_entry_t i_din,
    input  logic       i_pop,
    output logic       o_valid,
    output opf_entry_t o_dout,
    output logic [1:0] o_count
);

    opf_entry_t r_mem [2];
    logic       r_head;
    logic [1:0] r_count;
    logic       w_wptr;

    // When full, a push is only legal alongside a pop, so it reuses the head slot.
    assign w_wptr = r_head ^ (r_count == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head   <= 1'b0;
            r_count  <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (i_push)
                r_mem[w_wptr] <= i_din;
            if (i_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_dout  = o_valid ? r_mem[r_head] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/regfile_opfetch.sv
// Operand fetch front end for a 2R/1W register file with hazard scoreboard.
// Define OPF_BYPASS_EN to forward a same-cycle writeback instead of stalling.
module regfile_opfetch
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] iss_rs0,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rd,
    input  logic          iss_we,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [AW-1:0] rf_r0addr,
    output logic [AW-1:0] rf_r1addr,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_wena,
    input  logic [DW-1:0] rf_r0data,
    input  logic [DW-1:0] rf_r1data,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [AW-1:0] op_rd,
    output logic          op_we
);

    sb_vec_t       r_busy;
    sb_vec_t       w_busy_nxt;
    logic          r_inflight;
    logic [AW-1:0] r_rd;
    logic          r_we;
    logic          w_wb_rs0;
    logic          w_wb_rs1;
    logic          w_wb_rd;
    logic          w_raw0;
    logic          w_raw1;
    logic          w_waw;
    logic          w_hazard;
    logic          w_pop;
    logic          w_accept;
    logic [1:0]    w_count;
    logic [1:0]    w_occ;
    logic          w_op_valid;
    opf_entry_t    w_push_ent;
    opf_entry_t    w_head;

    assign rf_r0addr = iss_rs0;
    assign rf_r1addr = iss_rs1;
    assign rf_waddr  = wb_addr;
    assign rf_wdata  = wb_data;
    assign rf_wena   = wb_valid;

    assign w_wb_rs0 = wb_valid && (wb_addr == iss_rs0);
    assign w_wb_rs1 = wb_valid && (wb_addr == iss_rs1);
    assign w_wb_rd  = wb_valid && (wb_addr == iss_rd);

`ifdef OPF_BYPASS_EN
    logic          r_fwd0;
    logic          r_fwd1;
    logic [DW-1:0] r_fwd_data;

    assign w_raw0 = r_busy[iss_rs0] && !w_wb_rs0;
    assign w_raw1 = r_busy[iss_rs1] && !w_wb_rs1;

    // Regfile returns pre-write data on a same-edge write, so capture it here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd0     <= 1'b0;
            r_fwd1     <= 1'b0;
            r_fwd_data <= '0;
        end else if (w_accept) begin
            r_fwd0     <= w_wb_rs0;
            r_fwd1     <= w_wb_rs1;
            r_fwd_data <= wb_data;
        end
    end

    assign w_push_ent.a = r_fwd0 ? r_fwd_data : rf_r0data;
    assign w_push_ent.b = r_fwd1 ? r_fwd_data : rf_r1data;
`else
    assign w_raw0 = r_busy[iss_rs0] || w_wb_rs0;
    assign w_raw1 = r_busy[iss_rs1] || w_wb_rs1;

    assign w_push_ent.a = rf_r0data;
    assign w_push_ent.b = rf_r1data;
`endif

    assign w_push_ent.rd = r_rd;
    assign w_push_ent.we = r_we;

    assign w_waw    = iss_we && r_busy[iss_rd] && !w_wb_rd;
    assign w_hazard = w_raw0 || w_raw1 || w_waw;
    assign w_pop    = w_op_valid && op_ready;
    assign w_occ    = w_count + {1'b0, r_inflight};

    assign iss_ready = !rst && !w_hazard &&
                       ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
    assign w_accept  = iss_valid && iss_ready;

    // Clear first so a same-index set in the same cycle wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid)
            w_busy_nxt[wb_addr] = 1'b0;
        if (w_accept && iss_we)
            w_busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_inflight <= 1'b0;
            r_rd       <= '0;
            r_we       <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_inflight <= w_accept;
            if (w_accept) begin
                r_rd <= iss_rd;
                r_we <= iss_we;
            end
        end
    end

    opf_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_valid (w_op_valid),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign op_valid = w_op_valid;
    assign op_a     = w_head.a;
    assign op_b     = w_head.b;
    assign op_rd    = w_head.rd;
    assign op_we    = w_head.we;

endmodule

// File: tb/tb_regfile_opfetch.sv
// Randomized bench for regfile_opfetch against an architectural operand model.
module tb_regfile_opfetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [4:0]  iss_rs0 = '0;
    logic [4:0]  iss_rs1 = '0;
    logic [4:0]  iss_rd = '0;
    logic        iss_we = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic [4:0]  rf_r0addr;
    logic [4:0]  rf_r1addr;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        rf_wena;
    logic [63:0] rf_r0data = '0;
    logic [63:0] rf_r1data = '0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [4:0]  op_rd;
    logic        op_we;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_opfetch dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs0(iss_rs0), .iss_rs1(iss_rs1),
        .iss_rd(iss_rd), .iss_we(iss_we),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_r0addr(rf_r0addr), .rf_r1addr(rf_r1addr),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wena(rf_wena),
        .rf_r0data(rf_r0data), .rf_r1data(rf_r1data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_we(op_we)
    );

    // Register file with registered reads: same-edge write returns old data.
    logic [63:0] rf_mem [32];
    bit          rf_loaded = 1'b0;

    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++)
                rf_mem[i] <= 64'(i * 'h11);
            rf_loaded <= 1'b1;
        end else begin
            if (rf_wena)
                rf_mem[rf_waddr] <= rf_wdata;
            rf_r0data <= rf_mem[rf_r0addr];
            rf_r1data <= rf_mem[rf_r1addr];
        end
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        we;
        int          age;
    } exp_op_t;

    logic [63:0] arch [32];
    bit          pend [32];
    exp_op_t     q [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit raw(input int rs, input bit wbv, input int wba);
        bit m = wbv && (wba == rs);
`ifdef OPF_BYPASS_EN
        return pend[rs] && !m;
`else
        return pend[rs] || m;
`endif
    endfunction

    task automatic step(input bit v, input int rs0, input int rs1,
                        input int rd, input bit we, input bit wbv,
                        input int wba, input logic [63:0] wbd,
                        input bit ordy);
        bit      exp_valid, exp_pop, hz, exp_ready, acc;
        exp_op_t e;
        @(negedge clk);
        iss_valid = v;
        iss_rs0   = 5'(rs0);
        iss_rs1   = 5'(rs1);
        iss_rd    = 5'(rd);
        iss_we    = we;
        wb_valid  = wbv;
        wb_addr   = 5'(wba);
        wb_data   = wbd;
        op_ready  = ordy;
        #1;
        exp_valid = (q.size() > 0) && (q[0].age >= 1);
        exp_pop   = exp_valid && ordy;
        hz = raw(rs0, wbv, wba) || raw(rs1, wbv, wba) ||
             (we && pend[rd] && !(wbv && wba == rd));
        exp_ready = !hz && (q.size() < 2 || (q.size() == 2 && exp_pop));
        acc = v && exp_ready;
        chk("iss_ready", iss_ready, exp_ready);
        chk("op_valid", op_valid, exp_valid);
        chk("rf_r0addr", rf_r0addr, 5'(rs0));
        chk("rf_wena", rf_wena, wbv);
        if (exp_valid) begin
            chk("op_a", op_a, q[0].a);
            chk("op_b", op_b, q[0].b);
            chk("op_rd", op_rd, q[0].rd);
            chk("op_we", op_we, q[0].we);
        end
        if (exp_pop)
            void'(q.pop_front());
        foreach (q[i])
            q[i].age++;
        if (acc) begin
            e.a  = (wbv && wba == rs0) ? wbd : arch[rs0];
            e.b  = (wbv && wba == rs1) ? wbd : arch[rs1];
            e.rd = 5'(rd);
            e.we = we;
            e.age = 0;
            q.push_back(e);
        end
        if (wbv) begin
            arch[wba] = wbd;
            pend[wba] = 1'b0;
        end
        if (acc && we)
            pend[rd] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        iss_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_rd", op_rd, 0);
        q.delete();
        foreach (pend[i])
            pend[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            arch[i] = 64'(i * 'h11);
            pend[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        // Latency and back-to-back throughput
        step(1, 3, 4, 0, 0, 0, 0, 0, 1);
        step(1, 4, 3, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("lat_a0", op_a, 64'h33);
        chk("lat_b0", op_b, 64'h44);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("lat_a1", op_a, 64'h44);
        idle(2);

        // Backpressure: third issue refused until downstream drains
        for (int i = 0; i < 3; i++)
            step(1, i + 1, i + 2, i, 0, 0, 0, 0, 0);
        chk("bp_ready", iss_ready, 0);
        step(1, 6, 7, 2, 0, 0, 0, 0, 0);
        idle(6);

        // RAW on rd=5 resolved by writeback 0xAB
        step(1, 0, 0, 5, 1, 0, 0, 0, 1);
        step(1, 5, 0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 0, 0, 0, 1, 5, 64'hAB, 1);
`ifdef OPF_BYPASS_EN
        chk("raw_bypass_ready", iss_ready, 1);
`else
        chk("raw_stall_ready", iss_ready, 0);
        step(1, 5, 0, 0, 0, 0, 0, 0, 1);
`endif
        idle(4);

        // WAW on rd=7, then same-cycle clear and re-set
        step(1, 0, 0, 7, 1, 0, 0, 0, 1);
        step(1, 0, 0, 7, 1, 0, 0, 0, 1);
        chk("waw_ready", iss_ready, 0);
        step(1, 0, 0, 7, 1, 1, 7, 64'h77, 1);
        step(1, 0, 0, 7, 1, 0, 0, 0, 1);
        chk("waw_reset_busy", iss_ready, 0);
        step(0, 0, 0, 0, 0, 1, 7, 64'h78, 1);
        idle(4);

        // Reset with buffered and in-flight operands
        step(1, 3, 4, 9, 1, 0, 0, 0, 0);
        step(1, 4, 3, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(1, 9, 3, 0, 0, 0, 0, 0, 1);
        idle(2);
        chk("post_rst_a", op_a, arch[9]);

        // Random traffic on a small register window to force hazards
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699)
                do_reset();
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 7),
                 {$urandom, $urandom}, $urandom_range(0, 9) < 7);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
